sign_zero_extend: RTL and testbench
===================================

Name: sign_zero_extend

Overview:
Load-data alignment and extension unit for the RISC-V datapath. It sits between data memory and the register-file write-back mux.
- Takes the raw 32-bit memory word, the load opcode (controls::mem_op) and the low two address bits.
- Selects the addressed byte or halfword (little-endian) and sign- or zero-extends it to Word_size.
- Output is registered: one-cycle latency. Also flags misaligned accesses.

Parameters:
- Word_size, 32, width of mem_word and dout. Legal values are 32 or 64. Byte/halfword lanes are always taken from mem_word[31:0]; extension fills bits up to Word_size-1.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- mem_word  input  Word_size  raw word read from data memory
- op  input  mem_op (controls package enum)  memory operation: LB, LH, LW, LBU, LHU, stores/none
- byte_addr  input  2  low address bits, effective address [1:0]
- dout  output  Word_size  aligned, extended load data (registered)
- misalign  output  1  registered flag: misaligned access for the current op

Behaviour:
- Reset: while rst=1, dout=0 and misalign=0 immediately, independent of clk. Both stay 0 until the first rising clk edge after rst falls.
- Latency: inputs are sampled on each rising clk edge; dout and misalign reflect that sample until the next edge. There is no handshake, so a new op is accepted every cycle.

Byte select (LB/LBU), little-endian:
- byte_addr 00 -> mem_word[7:0]
- byte_addr 01 -> mem_word[15:8]
- byte_addr 10 -> mem_word[23:16]
- byte_addr 11 -> mem_word[31:24]

Halfword select (LH/LHU):
- byte_addr[1]=0 -> mem_word[15:0]
- byte_addr[1]=1 -> mem_word[31:16]
- byte_addr[0] is ignored for data selection.

Extension:
- LB: selected byte bit 7 replicated into dout[Word_size-1:8].
- LBU: zeros above bit 7.
- LH: halfword bit 15 replicated into dout[Word_size-1:16].
- LHU: zeros above bit 15.
- LW: dout = mem_word[31:0], sign-extended from bit 31 when Word_size=64. byte_addr is ignored.
- Any other op value (stores, none, unused enum codes): dout = mem_word, pass-through.

misalign:
- 1 for LH/LHU with byte_addr[0]=1.
- 1 for LW with byte_addr != 00.
- 0 for LB, LBU and all non-load ops.
- Data is still produced per the selection rules above; misalign is advisory only.

Boundary conditions:
- op changes while byte_addr is held, or vice versa: the result depends only on the values sampled at the edge.
- rst asserted mid-stream: outputs clear asynchronously and the in-flight result is discarded.
- rst deasserted: the first valid output appears after the first subsequent rising edge.

Implementation:
- Selection and extension are purely combinational.
- Two always_ff registers with the async reset.
- No X propagation for undefined op encodings: use a default branch.

Test Plan:
- Setup for all scenarios: mem_word=32'hFF81_0FF0, Word_size=32. Outputs are checked one clk after each input change.
- Reset: assert rst mid-cycle -> dout=0, misalign=0 immediately without a clk edge. Deassert, apply LW/00 -> after 1 edge dout=32'hFF810FF0, misalign=0.
- Byte loads:
  - LB/00 -> 32'hFFFFFFF0
  - LB/10 -> 32'hFFFFFF81
  - LBU/10 -> 32'h00000081
  - LB/01 -> 32'h0000000F
  - LBU/11 -> 32'h000000FF
  - misalign=0 throughout
- Halfword loads:
  - LH/00 -> 32'h00000FF0
  - LH/10 -> 32'hFFFFFF81
  - LHU/10 -> 32'h0000FF81
  - LHU/00 -> 32'h00000FF0
- Misalignment:
  - LH/01 -> dout=32'h00000FF0, misalign=1
  - LW/10 -> dout=32'hFF810FF0, misalign=1
  - LB/11 -> misalign=0
- Latency/back-to-back: change op every cycle (LW, LB, LBU, LH, LHU) at byte_addr 10 -> each result appears exactly one edge later: FF810FF0, FFFFFF81, 00000081, FFFFFF81, 0000FF81. No stale or skipped values.
- Non-load op (a store): dout=mem_word, misalign=0. With Word_size=64, LW with mem_word[31]=1 -> upper 32 bits all ones.

Source files
------------

// File: rtl/sign_zero_extend.sv
// Load-data alignment and extension unit.
//
// Sits between data memory and the register-file write-back mux. It picks the
// addressed byte or halfword out of the raw memory word (little-endian), then
// sign- or zero-extends it to Word_size. The result and a misaligned-access
// flag are registered, so results appear one cycle after the inputs.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset; clears dout and misalign
//   mem_word   raw word read from data memory (Word_size bits)
//   op         memory operation (controls::mem_op)
//   byte_addr  effective address [1:0]
//   dout       aligned, extended load data (registered)
//   misalign   registered advisory flag: misaligned access for the sampled op

package controls;

    typedef enum logic [3:0] {
        MemNone = 4'd0,
        MemLb   = 4'd1,
        MemLh   = 4'd2,
        MemLw   = 4'd3,
        MemLbu  = 4'd4,
        MemLhu  = 4'd5,
        MemSb   = 4'd6,
        MemSh   = 4'd7,
        MemSw   = 4'd8
    } mem_op;

endpackage

module sign_zero_extend #(
    parameter int unsigned Word_size = 32  // 32 or 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [Word_size-1:0] mem_word,
    input  controls::mem_op      op,
    input  logic [1:0]           byte_addr,
    output logic [Word_size-1:0] dout,
    output logic                 misalign
);

    logic [7:0]           sel_byte;
    logic [15:0]          sel_half;
    logic [Word_size-1:0] dout_d;
    logic                 misalign_d;

    // Lanes always come from the low 32 bits, even for a 64-bit datapath.
    always_comb begin
        sel_byte = mem_word[7:0];
        case (byte_addr)
            2'b00:   sel_byte = mem_word[7:0];
            2'b01:   sel_byte = mem_word[15:8];
            2'b10:   sel_byte = mem_word[23:16];
            default: sel_byte = mem_word[31:24];
        endcase
    end

    // byte_addr[0] does not affect halfword data, only the misalign flag.
    assign sel_half = byte_addr[1] ? mem_word[31:16] : mem_word[15:0];

    // Signed size casts give sign extension without zero-width replications
    // when Word_size is 32.
    always_comb begin
        dout_d     = mem_word;
        misalign_d = 1'b0;
        case (op)
            controls::MemLb:  dout_d = Word_size'($signed(sel_byte));
            controls::MemLbu: dout_d = Word_size'(sel_byte);
            controls::MemLh: begin
                dout_d     = Word_size'($signed(sel_half));
                misalign_d = byte_addr[0];
            end
            controls::MemLhu: begin
                dout_d     = Word_size'(sel_half);
                misalign_d = byte_addr[0];
            end
            controls::MemLw: begin
                dout_d     = Word_size'($signed(mem_word[31:0]));
                misalign_d = |byte_addr;
            end
            // Stores, none and unused encodings pass the word straight through.
            default: begin
                dout_d     = mem_word;
                misalign_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout <= '0;
        end else begin
            dout <= dout_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misalign <= 1'b0;
        end else begin
            misalign <= misalign_d;
        end
    end

endmodule

// File: tb/tb_sign_zero_extend.sv
// Self-checking bench for sign_zero_extend.
//
// Drives a 32-bit and a 64-bit instance with identical ops and addresses.
// Expected 32-bit results are table constants; expected 64-bit results come
// from a small reference model. Expectations are queued when stimulus is
// driven and popped one clock later when the registered outputs are valid.

module tb_sign_zero_extend;
    import controls::*;

    logic        clk;
    logic        rst;
    logic [31:0] mem_word32;
    logic [63:0] mem_word64;
    mem_op       op;
    logic [1:0]  byte_addr;
    logic [31:0] dout32;
    logic [63:0] dout64;
    logic        misalign32;
    logic        misalign64;

    int checks_total;
    int checks_passed;

    typedef struct {
        mem_op       o;
        logic [1:0]  a;
        logic [31:0] e;
        logic        m;
    } exp_t;

    exp_t sb_q[$];

    sign_zero_extend #(.Word_size(32)) u_dut32 (
        .clk       (clk),
        .rst       (rst),
        .mem_word  (mem_word32),
        .op        (op),
        .byte_addr (byte_addr),
        .dout      (dout32),
        .misalign  (misalign32)
    );

    sign_zero_extend #(.Word_size(64)) u_dut64 (
        .clk       (clk),
        .rst       (rst),
        .mem_word  (mem_word64),
        .op        (op),
        .byte_addr (byte_addr),
        .dout      (dout64),
        .misalign  (misalign64)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks_total++;
        if (got === exp) begin
            checks_passed++;
        end else begin
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Reference model for the 64-bit datapath.
    function automatic logic [63:0] model64(input logic [63:0] w, input mem_op o,
                                            input logic [1:0] a);
        logic [31:0] lo;
        logic [7:0]  b;
        logic [15:0] h;
        logic [63:0] r;
        lo = w[31:0];
        b  = 8'(lo >> (8 * a));
        h  = a[1] ? lo[31:16] : lo[15:0];
        r  = w;
        if (o == MemLb)  r = {{56{b[7]}}, b};
        if (o == MemLbu) r = {56'd0, b};
        if (o == MemLh)  r = {{48{h[15]}}, h};
        if (o == MemLhu) r = {48'd0, h};
        if (o == MemLw)  r = {{32{lo[31]}}, lo};
        return r;
    endfunction

    task automatic score();
        exp_t ent;
        string id;
        if (sb_q.size() > 0) begin
            ent = sb_q.pop_front();
            id  = $sformatf("%s/%0d", ent.o.name(), ent.a);
            check({"dout32 ", id}, {32'd0, dout32}, {32'd0, ent.e});
            check({"mis32 ", id}, {63'd0, misalign32}, {63'd0, ent.m});
            check({"dout64 ", id}, dout64, model64(mem_word64, ent.o, ent.a));
            check({"mis64 ", id}, {63'd0, misalign64}, {63'd0, ent.m});
        end
    endtask

    // Called at a negedge: score the previous sample, drive a new one, wait a cycle.
    task automatic step(input mem_op o, input logic [1:0] a, input logic [31:0] e,
                        input logic m);
        exp_t ent;
        score();
        op        = o;
        byte_addr = a;
        ent.o = o;
        ent.a = a;
        ent.e = e;
        ent.m = m;
        sb_q.push_back(ent);
        @(negedge clk);
    endtask

    initial begin
        checks_total  = 0;
        checks_passed = 0;
        mem_word32    = 32'hFF81_0FF0;
        mem_word64    = {32'hA5A5_5A5A, 32'hFF81_0FF0};
        op            = MemLw;
        byte_addr     = 2'b10;
        rst           = 1'b1;

        #1;
        check("reset dout32", {32'd0, dout32}, 64'd0);
        check("reset mis32", {63'd0, misalign32}, 64'd0);
        check("reset dout64", dout64, 64'd0);
        @(negedge clk);
        check("reset held dout32", {32'd0, dout32}, 64'd0);
        check("reset held mis32", {63'd0, misalign32}, 64'd0);
        rst = 1'b0;

        step(MemLw,  2'b00, 32'hFF81_0FF0, 1'b0);
        // Byte loads
        step(MemLb,  2'b00, 32'hFFFF_FFF0, 1'b0);
        step(MemLb,  2'b10, 32'hFFFF_FF81, 1'b0);
        step(MemLbu, 2'b10, 32'h0000_0081, 1'b0);
        step(MemLb,  2'b01, 32'h0000_000F, 1'b0);
        step(MemLbu, 2'b11, 32'h0000_00FF, 1'b0);
        // Halfword loads
        step(MemLh,  2'b00, 32'h0000_0FF0, 1'b0);
        step(MemLh,  2'b10, 32'hFFFF_FF81, 1'b0);
        step(MemLhu, 2'b10, 32'h0000_FF81, 1'b0);
        step(MemLhu, 2'b00, 32'h0000_0FF0, 1'b0);
        // Misalignment
        step(MemLh,  2'b01, 32'h0000_0FF0, 1'b1);
        step(MemLhu, 2'b11, 32'h0000_FF81, 1'b1);
        step(MemLw,  2'b10, 32'hFF81_0FF0, 1'b1);
        step(MemLw,  2'b01, 32'hFF81_0FF0, 1'b1);
        step(MemLb,  2'b11, 32'hFFFF_FFFF, 1'b0);
        // Back-to-back op changes at a fixed address
        step(MemLw,  2'b10, 32'hFF81_0FF0, 1'b1);
        step(MemLb,  2'b10, 32'hFFFF_FF81, 1'b0);
        step(MemLbu, 2'b10, 32'h0000_0081, 1'b0);
        step(MemLh,  2'b10, 32'hFFFF_FF81, 1'b0);
        step(MemLhu, 2'b10, 32'h0000_FF81, 1'b0);
        // Address changes with op held
        step(MemLbu, 2'b00, 32'h0000_00F0, 1'b0);
        step(MemLbu, 2'b01, 32'h0000_000F, 1'b0);
        // Non-load ops pass the word through
        step(MemSw,   2'b00, 32'hFF81_0FF0, 1'b0);
        step(MemSh,   2'b11, 32'hFF81_0FF0, 1'b0);
        step(MemNone, 2'b01, 32'hFF81_0FF0, 1'b0);
        step(mem_op'(4'hF), 2'b11, 32'hFF81_0FF0, 1'b0);

        // Mid-stream reset: the LW/10 result in flight is discarded.
        step(MemLw, 2'b10, 32'hFF81_0FF0, 1'b1);
        check("pre-reset dout32", {32'd0, dout32}, 64'h0000_0000_FF81_0FF0);
        #2 rst = 1'b1;
        #1;
        check("async reset dout32", {32'd0, dout32}, 64'd0);
        check("async reset mis32", {63'd0, misalign32}, 64'd0);
        check("async reset dout64", dout64, 64'd0);
        check("async reset mis64", {63'd0, misalign64}, 64'd0);
        sb_q.delete();
        @(posedge clk);
        #1;
        check("reset over edge dout32", {32'd0, dout32}, 64'd0);
        check("reset over edge mis32", {63'd0, misalign32}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        step(MemLb, 2'b10, 32'hFFFF_FF81, 1'b0);
        step(MemLh, 2'b01, 32'h0000_0FF0, 1'b1);
        score();

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
